// File: rtl/video_pattern_tx.sv
// video_pattern_tx: video timing source with a 32x32 gray patch window.
// Generates vsync/hsync/de/data for the vi_* capture path. Pixels inside the
// patch window are replayed from an external 1024x8 read port. All other
// active pixels get the background colour.
// Optional build macro VTX_COLORBAR_EN: background becomes eight vertical
// colour bars. Without it, the background is the constant BG_COLOR.
// Pipeline: counters/stage0 -> stage1 regs -> vo_* regs (2 clk latency).
// Read port contract: cena=0 with aa presented in a cycle; qa is valid in
// the following cycle.
`timescale 1ns/1ps
module video_pattern_tx #(
    parameter int          H_ACTIVE = 1920,
    parameter int          H_FP     = 88,
    parameter int          H_SYNC   = 44,
    parameter int          H_BP     = 148,
    parameter int          V_ACTIVE = 1080,
    parameter int          V_FP     = 4,
    parameter int          V_SYNC   = 5,
    parameter int          V_BP     = 36,
    parameter bit          SYNC_POL = 1'b1,
    parameter int          X0       = 960,
    parameter int          Y0       = 540,
    parameter logic [23:0] BG_COLOR = 24'h101010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        cena,
    output logic [9:0]  aa,
    input  logic [7:0]  qa,
    output logic        vo_vsync,
    output logic        vo_hsync,
    output logic        vo_de,
    output logic [23:0] vo_data,
    output logic        frame_start
);
    localparam int PATCH   = 32;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_BEG  = HW'(X0);
    localparam logic [HW-1:0] X_END  = HW'(X0 + PATCH);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_BEG  = VW'(Y0);
    localparam logic [VW-1:0] Y_END  = VW'(Y0 + PATCH);

    // The patch must sit entirely inside the active area.
    generate
        if (X0 + PATCH > H_ACTIVE || Y0 + PATCH > V_ACTIVE) begin : g_bad_patch
            $error("video_pattern_tx: patch window exceeds active area");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // Run/idle control and raster counters; a started frame always completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                            if (!en) state <= IDLE;
                        end else begin
                            v_cnt <= v_cnt + VW'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic        run;
    logic        de0, hs0, vs0, patch0, fs0;
    logic [4:0]  col0, row0;
    logic [23:0] bg0;

    // Stage 0: timing decode of the current counter position.
    always_comb begin
        run    = (state == RUN);
        de0    = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs0    = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs0    = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        patch0 = de0 && (h_cnt >= X_BEG) && (h_cnt < X_END)
                     && (v_cnt >= Y_BEG) && (v_cnt < Y_END);
        fs0    = run && (h_cnt == '0) && (v_cnt == '0);
        col0   = h_cnt[4:0] - X_BEG[4:0];
        row0   = v_cnt[4:0] - Y_BEG[4:0];
    end

`ifdef VTX_COLORBAR_EN
    logic [HW+2:0] bar_num;
    logic [2:0]    bar;

    // Background: eight equal-width bars across the active line.
    always_comb begin
        bar_num = {h_cnt, 3'b000} / (HW+3)'(H_ACTIVE);
        bar     = bar_num[2:0];
        case (bar)
            3'd0:    bg0 = 24'hFFFFFF;
            3'd1:    bg0 = 24'hFFFF00;
            3'd2:    bg0 = 24'h00FFFF;
            3'd3:    bg0 = 24'h00FF00;
            3'd4:    bg0 = 24'hFF00FF;
            3'd5:    bg0 = 24'hFF0000;
            3'd6:    bg0 = 24'h0000FF;
            default: bg0 = 24'h000000;
        endcase
    end
`else
    // Background: fixed fill colour.
    always_comb begin
        bg0 = BG_COLOR;
    end
`endif

    logic [9:0] aa_hold;

    // Remember the last address issued so aa is stable while cena is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         aa_hold <= '0;
        else if (patch0) aa_hold <= {row0, col0};
    end

    assign cena = ~patch0;
    assign aa   = patch0 ? {row0, col0} : aa_hold;

    logic        de1, hs1, vs1, patch1, fs1;
    logic [23:0] bg1;

    // Stage 1: align timing with the buffer read cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de1    <= 1'b0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            patch1 <= 1'b0;
            fs1    <= 1'b0;
            bg1    <= '0;
        end else begin
            de1    <= de0;
            hs1    <= hs0;
            vs1    <= vs0;
            patch1 <= patch0;
            fs1    <= fs0;
            bg1    <= bg0;
        end
    end

    // Stage 2: output registers; qa is valid here for patch pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vo_de       <= 1'b0;
            vo_data     <= '0;
            vo_hsync    <= ~SYNC_POL;
            vo_vsync    <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vo_de       <= de1;
            vo_data     <= patch1 ? {qa, qa, qa} : (de1 ? bg1 : 24'h000000);
            vo_hsync    <= SYNC_POL ? hs1 : ~hs1;
            vo_vsync    <= SYNC_POL ? vs1 : ~vs1;
            frame_start <= fs1;
        end
    end
endmodule
